ps2_rx_fifo: RTL and testbench

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/ps2_rx_fifo.sv | 154 +++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: FSM state encoding and frame constants.
package ps2_pkg;

  // Receiver FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  // PS/2 frame: start(0), 8 data bits LSB-first, odd parity, stop(1)
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned BCNT_W     = $clog2(DATA_BITS);
  localparam logic        ODD_PARITY = 1'b1;

  // True when the data bits plus the parity bit carry odd parity
  function automatic logic parity_ok(input logic [DATA_BITS-1:0] data, input logic par);
    return (^{data, par}) == ODD_PARITY;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. A push while full is accepted only when a pop
// happens on the same edge; pops on an empty FIFO are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = count_q;
  // Head byte is forced to zero when empty so reset presents rd_data = 0
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  // Next pointer and occupancy; pointers wrap naturally at power-of-two depth
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written at the write pointer on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver feeding a byte FIFO, with error pulses and a
// sticky overflow flag.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | line idle, waiting for a falling edge with data=0 (start bit)
// ST_DATA   | shifting in 8 data bits LSB-first
// ST_PARITY | next falling edge captures the parity bit
// ST_STOP   | next falling edge checks stop bit and parity, pushes or flags
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ps2_clk,
  input  logic                       ps2_data,
  input  logic                       rd_en,
  input  logic                       clr_err,
  output logic [7:0]                 rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       parity_err,
  output logic                       frame_err,
  output logic                       overflow
);

  localparam int TW = $clog2(TIMEOUT+1);

  logic [2:0]           ps2c_q;
  logic [1:0]           ps2d_q;
  logic                 fe, din;
  rx_state_e            state_q, state_d;
  logic [BCNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overflow_q, overflow_d;
  logic                 push, fifo_full, fifo_empty;

  // Two stages synchronise the lines; the third clock stage gives the edge
  assign fe  = ps2c_q[2] & ~ps2c_q[1];
  assign din = ps2d_q[1];

  // Line synchronisers, reset to the idle-high level
  always_ff @(posedge clk) begin
    if (rst) begin
      ps2c_q <= '1;
      ps2d_q <= '1;
    end else begin
      ps2c_q <= {ps2c_q[1:0], ps2_clk};
      ps2d_q <= {ps2d_q[0], ps2_data};
    end
  end

  // Frame FSM, inter-edge timeout and error/push decisions
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    tmo_d        = tmo_q;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    push         = 1'b0;

    if (fe)                tmo_d = TW'(TIMEOUT);
    else if (tmo_q != '0)  tmo_d = tmo_q - 1'b1;

    if (fe) begin
      case (state_q)
        ST_IDLE: begin
          if (!din) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {din, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BCNT_W'(DATA_BITS-1)) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = din;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          // A bad stop bit outranks a parity error
          if (!din)                          frame_err_d  = 1'b1;
          else if (!parity_ok(shift_q, par_q)) parity_err_d = 1'b1;
          else                               push         = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && tmo_q == '0) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
    end

    // Overflow when a byte is dropped; a coincident set beats clr_err
    overflow_d = overflow_q;
    if (clr_err)                         overflow_d = 1'b0;
    if (push && fifo_full && !rd_en)     overflow_d = 1'b1;
  end

  // Receiver state and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (rd_en),
    .wdata (shift_q),
    .rdata (rd_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rd_valid   = ~fifo_empty;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Randomised bench for ps2_rx_fifo against a queue-based model of the
// receiver and FIFO behaviour.
module tb_ps2_rx_fifo;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 200;
  localparam int HALF    = 20;
  localparam int CW      = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst, ps2_clk, ps2_data, rd_en, clr_err;
  logic [7:0]    rd_data;
  logic          rd_valid, parity_err, frame_err, overflow;
  logic [CW-1:0] fifo_count;

  ps2_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rd_en      (rd_en),
    .clr_err    (clr_err),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_count (fifo_count),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pe_cnt   = 0;
  int fr_cnt   = 0;

  logic [7:0] mq[$];
  logic       m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (parity_err === 1'b1) pe_cnt++;
    if (frame_err === 1'b1)  fr_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, ":count"},    32'(fifo_count), mq.size());
    check({tag, ":rd_valid"}, 32'(rd_valid),   32'(mq.size() > 0));
    check({tag, ":overflow"}, 32'(overflow),   32'(m_ovf));
    if (mq.size() > 0) check({tag, ":head"}, 32'(rd_data), 32'(mq[0]));
  endtask

  // strobe: 0 none, 1 rd_en on the stop-edge push cycle, 2 clr_err on it
  task automatic send_bits(input logic [10:0] bits, input int n, input int strobe);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      idle(HALF);
      ps2_clk = 1'b0;
      if (i == n-1 && strobe != 0) begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        if (strobe == 1) rd_en = 1'b1; else clr_err = 1'b1;
        @(negedge clk);
        rd_en   = 1'b0;
        clr_err = 1'b0;
        idle(HALF-3);
      end else begin
        idle(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    idle(4);
  endtask

  // kind: 0 good frame, 1 bad parity, 2 bad stop bit
  task automatic send_frame(input logic [7:0] d, input int kind, input int strobe, input string tag);
    logic par, stop;
    int   pe0, fr0;
    par  = ~^d;
    if (kind == 1) par = ~par;
    stop = (kind != 2);
    pe0  = pe_cnt;
    fr0  = fr_cnt;
    send_bits({stop, par, d, 1'b0}, 11, strobe);
    if (strobe == 2) m_ovf = 1'b0;
    if (kind == 0) begin
      if (strobe == 1 && mq.size() > 0) void'(mq.pop_front());
      if (mq.size() < DEPTH) mq.push_back(d);
      else                   m_ovf = 1'b1;
    end
    check({tag, ":parity_err"}, pe_cnt - pe0, 32'(kind == 1));
    check({tag, ":frame_err"},  fr_cnt - fr0, 32'(kind == 2));
    check_state(tag);
  endtask

  task automatic pop1(input string tag);
    @(negedge clk);
    if (mq.size() > 0) check({tag, ":pop_head"}, 32'(rd_data), 32'(mq[0]));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic drain(input string tag);
    while (mq.size() > 0) pop1(tag);
    check_state({tag, ":drained"});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    idle(2);
  endtask

  initial begin
    int pe0, fr0, kind, k;
    logic [7:0] d;
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rd_en    = 1'b0;
    clr_err  = 1'b0;
    m_ovf    = 1'b0;
    do_reset();

    check("rst:rd_data",    32'(rd_data),    0);
    check("rst:rd_valid",   32'(rd_valid),   0);
    check("rst:count",      32'(fifo_count), 0);
    check("rst:parity_err", 32'(parity_err), 0);
    check("rst:frame_err",  32'(frame_err),  0);
    check("rst:overflow",   32'(overflow),   0);

    send_frame(8'h1C, 0, 0, "good_1C");
    send_frame(8'hF0, 1, 0, "badpar_F0");
    send_frame(8'h1C, 2, 0, "badstop_1C");

    // Lone falling edge with data high in idle must be ignored
    pe0 = pe_cnt; fr0 = fr_cnt;
    send_bits(11'h7FF, 1, 0);
    idle(TIMEOUT + 10);
    check("idle_hi:frame_err",  fr_cnt - fr0, 0);
    check("idle_hi:parity_err", pe_cnt - pe0, 0);
    check_state("idle_hi");

    // Frame stalled after four data bits
    pe0 = pe_cnt; fr0 = fr_cnt;
    send_bits({1'b1, 1'b0, 8'h32, 1'b0}, 5, 0);
    idle(TIMEOUT + 10);
    check("timeout:frame_err",  fr_cnt - fr0, 1);
    check("timeout:parity_err", pe_cnt - pe0, 0);
    check_state("timeout");
    send_frame(8'h32, 0, 0, "after_tmo_32");

    // Read on empty must leave pointers alone
    drain("drain1");
    pop1("empty_pop");
    check_state("empty_pop");
    send_frame(8'h77, 0, 0, "after_empty_pop");

    // Random frames, reads and clears
    for (int i = 0; i < 30; i++) begin
      d    = 8'($urandom);
      k    = $urandom_range(0, 5);
      kind = (k < 4) ? 0 : k - 3;
      send_frame(d, kind, 0, "rand");
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, 3);
        for (int j = 0; j < k; j++) pop1("rand");
        check_state("rand_pop");
      end
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk); clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
        m_ovf = 1'b0;
        check_state("rand_clr");
      end
    end

    // Fill past capacity
    do_reset();
    for (int i = 0; i <= DEPTH; i++) send_frame(8'(8'h40 + i), 0, 0, "fill");
    check("fill:overflow", 32'(overflow),   1);
    check("fill:count",    32'(fifo_count), DEPTH);
    check("fill:head",     32'(rd_data),    32'h40);
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    m_ovf = 1'b0;
    check("clr:overflow", 32'(overflow), 0);

    // Push and pop on the same edge while full
    send_frame(8'hA5, 0, 1, "full_pushpop");
    check("full_pushpop:count", 32'(fifo_count), DEPTH);
    // Drop while full with a coincident clr_err: set wins
    send_frame(8'h5A, 0, 2, "full_clr_set");
    check("full_clr_set:overflow", 32'(overflow), 1);
    drain("drain_full");

    // Reset in the middle of a frame abandons it silently
    send_frame(8'h11, 0, 0, "pre_rst");
    pe0 = pe_cnt; fr0 = fr_cnt;
    send_bits({1'b1, 1'b1, 8'h99, 1'b0}, 6, 0);
    do_reset();
    idle(TIMEOUT + 10);
    check("midrst:frame_err",  fr_cnt - fr0, 0);
    check("midrst:parity_err", pe_cnt - pe0, 0);
    check_state("midrst");
    send_frame(8'hC3, 0, 0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
